// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Receives 4-byte command packets from a UART receiver and turns each valid
// one into a single register-write strobe, then answers with ACK or NAK.
//
//   Packet : SYNC_BYTE, ADDR, DATA, CSUM   (CSUM = SYNC_BYTE ^ ADDR ^ DATA)
//
// Ports
//   clk_i        in   sole clock, rising edge
//   reset_i      in   synchronous, active-high reset
//   rx_valid_i   in   one-cycle pulse, rx_byte_i holds a received byte
//   rx_byte_i    in   [7:0] received byte
//   tx_ready_i   in   transmitter takes tx_byte_o this cycle
//   wr_en_o      out  one-cycle register-write strobe
//   wr_addr_o    out  [7:0] write address (holds last captured value)
//   wr_data_o    out  [7:0] write data    (holds last captured value)
//   tx_valid_o   out  response byte pending
//   tx_byte_o    out  [7:0] ACK_BYTE or NAK_BYTE
//   err_count_o  out  [7:0] saturating count of checksum errors + timeouts
//   busy_o       out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15,
  parameter logic [19:0] TIMEOUT   = 20'd520800
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_byte_i,
  input  logic       tx_ready_i,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_byte_o,
  output logic [7:0] err_count_o,
  output logic       busy_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  localparam logic [19:0] TMO_LAST = TIMEOUT - 20'd1;

  logic [2:0]  state_reg, state_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic [7:0]  tx_byte_reg, tx_byte_next;
  logic [7:0]  err_reg;
  logic [19:0] tmo_reg, tmo_next;

  logic in_pkt;
  logic byte_take;
  logic tmo_hit;
  logic csum_ok;
  logic err_inc;

  // States that are waiting for the next byte of a packet.
  assign in_pkt    = (state_reg == ST_ADDR) || (state_reg == ST_DATA) ||
                     (state_reg == ST_CSUM);
  assign byte_take = in_pkt && rx_valid_i;

  // A byte arriving on the expiry cycle wins, so rx_valid_i gates the timeout.
  assign tmo_hit   = in_pkt && !rx_valid_i && (tmo_reg == TMO_LAST);

  assign csum_ok   = (rx_byte_i == (SYNC_BYTE ^ addr_reg ^ data_reg));

  assign err_inc   = tmo_hit ||
                     ((state_reg == ST_CSUM) && rx_valid_i && !csum_ok);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    tx_byte_next = tx_byte_reg;

    case (state_reg)
      ST_IDLE: begin
        if (rx_valid_i && (rx_byte_i == SYNC_BYTE)) begin
          state_next = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (rx_valid_i) begin
          addr_next  = rx_byte_i;
          state_next = ST_DATA;
        end else if (tmo_hit) begin
          state_next = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (rx_valid_i) begin
          data_next  = rx_byte_i;
          state_next = ST_CSUM;
        end else if (tmo_hit) begin
          state_next = ST_IDLE;
        end
      end

      ST_CSUM: begin
        if (rx_valid_i) begin
          if (csum_ok) begin
            state_next = ST_WRITE;
          end else begin
            // Bad checksum skips the write and answers straight away.
            tx_byte_next = NAK_BYTE;
            state_next   = ST_RESP;
          end
        end else if (tmo_hit) begin
          state_next = ST_IDLE;
        end
      end

      ST_WRITE: begin
        tx_byte_next = ACK_BYTE;
        state_next   = ST_RESP;
      end

      ST_RESP: begin
        if (tx_ready_i) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Inter-byte idle counter: restarts on entering ADDR and on every byte
  // taken in ADDR/DATA/CSUM, otherwise counts while a packet is open.
  always_comb begin
    tmo_next = 20'd0;
    if (in_pkt && !byte_take) begin
      tmo_next = tmo_reg + 20'd1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= 8'h00;
      data_reg    <= 8'h00;
      tx_byte_reg <= 8'h00;
      tmo_reg     <= 20'd0;
      err_reg     <= 8'h00;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      tx_byte_reg <= tx_byte_next;
      tmo_reg     <= tmo_next;
      if (err_inc && (err_reg != 8'hFF)) begin
        err_reg <= err_reg + 8'd1;
      end
    end
  end

  // Outputs are decoded from registered state, so each is glitch-free and
  // the write/response latencies fall directly out of the state sequence.
  assign wr_en_o     = (state_reg == ST_WRITE);
  assign tx_valid_o  = (state_reg == ST_RESP);
  assign wr_addr_o   = addr_reg;
  assign wr_data_o   = data_reg;
  assign tx_byte_o   = tx_byte_reg;
  assign err_count_o = err_reg;
  assign busy_o      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//
// Self-checking bench for uart_cmd_ctrl. Writes and responses are scoreboarded
// through queues filled when the checksum byte is driven; a negedge monitor
// pops and compares. A vector table covers typical packets, hand-written
// sequences cover latency, timeout, back-pressure, saturation and reset.
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam logic [19:0] TMO  = 20'd100;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [7:0]  ACK  = 8'h06;
  localparam logic [7:0]  NAK  = 8'h15;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rx_valid_i;
  logic [7:0] rx_byte_i;
  logic       tx_ready_i;
  logic       wr_en_o;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       tx_valid_o;
  logic [7:0] tx_byte_o;
  logic [7:0] err_count_o;
  logic       busy_o;

  always #5 clk_i = ~clk_i;

  uart_cmd_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rx_valid_i  (rx_valid_i),
    .rx_byte_i   (rx_byte_i),
    .tx_ready_i  (tx_ready_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_byte_o   (tx_byte_o),
    .err_count_o (err_count_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    logic       ok;
    logic [7:0] resp;
  } vec_t;

  vec_t vecs[7];

  logic [15:0] wr_q[$];
  logic [7:0]  rsp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int model_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    tick(1);
    rx_valid_i = 1'b0;
  endtask

  // Independent checksum model: pushes what the DUT must produce.
  task automatic push_exp(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    if (c == (SYNC ^ a ^ d)) begin
      wr_q.push_back({a, d});
      rsp_q.push_back(ACK);
    end else begin
      rsp_q.push_back(NAK);
      if (model_err < 255) model_err++;
    end
  endtask

  task automatic wait_idle(input int max, input string name);
    int i;
    i = 0;
    while (busy_o && i < max) begin
      tick(1);
      i++;
    end
    if (busy_o) chk({name, "_idle_timeout"}, busy_o, 1'b0);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_wr_en"},    wr_en_o,     1'b0);
    chk({name, "_tx_valid"}, tx_valid_o,  1'b0);
    chk({name, "_tx_byte"},  tx_byte_o,   8'h00);
    chk({name, "_wr_addr"},  wr_addr_o,   8'h00);
    chk({name, "_wr_data"},  wr_data_o,   8'h00);
    chk({name, "_err"},      err_count_o, 8'h00);
    chk({name, "_busy"},     busy_o,      1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (wr_en_o) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", wr_addr_o, wr_data_o);
        end else begin
          logic [15:0] e;
          e = wr_q.pop_front();
          chk("write_addr", wr_addr_o, e[15:8]);
          chk("write_data", wr_data_o, e[7:0]);
        end
      end
      if (tx_valid_o && tx_ready_i) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got %h, expected no response", tx_byte_o);
        end else begin
          logic [7:0] r;
          r = rsp_q.pop_front();
          chk("resp_byte", tx_byte_o, r);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stable;

    vecs[0] = '{8'hA5, 8'h10, 8'h3C, 8'h89, 1'b1, ACK};
    vecs[1] = '{8'hA5, 8'h10, 8'h3C, 8'h88, 1'b0, NAK};
    vecs[2] = '{8'hA5, 8'h00, 8'h00, 8'hA5, 1'b1, ACK};
    vecs[3] = '{8'hA5, 8'hFF, 8'hFF, 8'hA5, 1'b1, ACK};
    vecs[4] = '{8'hA5, 8'h12, 8'h34, 8'h83, 1'b1, ACK};
    vecs[5] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b1, ACK};
    vecs[6] = '{8'hA5, 8'h01, 8'h02, 8'h00, 1'b0, NAK};

    reset_i    = 1'b1;
    rx_valid_i = 1'b0;
    rx_byte_i  = 8'h00;
    tx_ready_i = 1'b1;
    tick(3);
    chk_reset_vals("reset");
    reset_i = 1'b0;
    tick(1);

    // Good packet: write one cycle after CSUM, ACK one cycle later.
    send(SYNC); tick(1); send(8'h10); send(8'h3C);
    push_exp(8'h10, 8'h3C, 8'h89);
    send(8'h89);
    chk("good_wr_en_latency", wr_en_o, 1'b1);
    chk("good_tx_valid_during_write", tx_valid_o, 1'b0);
    tick(1);
    chk("good_ack_valid", tx_valid_o, 1'b1);
    chk("good_ack_byte", tx_byte_o, ACK);
    chk("good_wr_en_one_cycle", wr_en_o, 1'b0);
    tick(1);
    chk("good_ack_one_cycle", tx_valid_o, 1'b0);
    chk("good_idle", busy_o, 1'b0);
    chk("good_err", err_count_o, 8'd0);
    $display("txn good_packet addr=10 data=3C");

    // Bad checksum: NAK one cycle after CSUM, no write.
    send(SYNC); send(8'h10); send(8'h3C);
    push_exp(8'h10, 8'h3C, 8'h88);
    send(8'h88);
    chk("nak_valid_latency", tx_valid_o, 1'b1);
    chk("nak_byte", tx_byte_o, NAK);
    chk("nak_no_write", wr_en_o, 1'b0);
    tick(1);
    chk("nak_err", err_count_o, model_err);
    chk("nak_idle", busy_o, 1'b0);
    $display("txn bad_checksum err=%0d", err_count_o);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].b0); send(vecs[i].b1); send(vecs[i].b2);
      if (vecs[i].ok) wr_q.push_back({vecs[i].b1, vecs[i].b2});
      rsp_q.push_back(vecs[i].resp);
      if (!vecs[i].ok && model_err < 255) model_err++;
      send(vecs[i].b3);
      wait_idle(10, "vec");
      chk("vec_err_count", err_count_o, model_err);
      $display("txn vec%0d %h %h %h %h resp=%h", i, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].resp);
    end

    // Leading junk then sync values used as data
    send(8'h00); send(8'hFF);
    chk("junk_ignored", busy_o, 1'b0);
    push_exp(8'hA5, 8'hA5, 8'hA5);
    send(SYNC); send(SYNC); send(SYNC); send(SYNC);
    wait_idle(10, "resync");
    chk("resync_err", err_count_o, model_err);
    $display("txn sync_as_data addr=A5 data=A5");

    // Timeout in DATA
    send(SYNC); send(8'h10);
    tick(int'(TMO) - 1);
    chk("timeout_not_early", busy_o, 1'b1);
    tick(1);
    chk("timeout_idle", busy_o, 1'b0);
    chk("timeout_no_resp", tx_valid_o, 1'b0);
    model_err++;
    chk("timeout_err", err_count_o, model_err);
    $display("txn timeout err=%0d", err_count_o);
    send(SYNC); send(8'h10); send(8'h3C);
    push_exp(8'h10, 8'h3C, 8'h89);
    send(8'h89);
    wait_idle(10, "after_timeout");
    chk("after_timeout_err", err_count_o, model_err);
    $display("txn good_after_timeout");

    // Byte arriving on the expiry cycle wins
    send(SYNC);
    tick(int'(TMO) - 1);
    send(8'h44);
    tick(int'(TMO) - 1);
    send(8'h55);
    push_exp(8'h44, 8'h55, SYNC ^ 8'h44 ^ 8'h55);
    send(SYNC ^ 8'h44 ^ 8'h55);
    wait_idle(10, "race");
    chk("race_no_err", err_count_o, model_err);
    $display("txn byte_vs_timeout");

    // Back-pressure: response held 50 cycles, extra bytes dropped
    tx_ready_i = 1'b0;
    send(SYNC); send(8'h20); send(8'h30);
    push_exp(8'h20, 8'h30, SYNC ^ 8'h20 ^ 8'h30);
    send(SYNC ^ 8'h20 ^ 8'h30);
    tick(1);
    stable = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid_o === 1'b1 && tx_byte_o === ACK) stable++;
      if (i % 7 == 3) send(SYNC);
      else tick(1);
    end
    chk("hold_stable_cycles", stable, 50);
    tx_ready_i = 1'b1;
    tick(1);
    chk("hold_idle_after_ready", busy_o, 1'b0);
    chk("hold_err", err_count_o, model_err);
    $display("txn backpressure stable=%0d", stable);

    // Error counter saturation
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kb;
      kb = k[7:0];
      send(SYNC); send(kb); send(kb);
      push_exp(kb, kb, SYNC ^ 8'h01);
      send(SYNC ^ 8'h01);
      wait_idle(10, "sat");
      chk("sat_err_count", err_count_o, model_err);
    end
    chk("sat_hold_ff", err_count_o, 8'hFF);
    $display("txn saturation err=%h", err_count_o);

    // Reset during DATA, with a coincident byte
    send(SYNC); send(8'h10);
    reset_i    = 1'b1;
    rx_valid_i = 1'b1;
    rx_byte_i  = SYNC;
    tick(1);
    rx_valid_i = 1'b0;
    chk_reset_vals("mid_data_reset");
    reset_i   = 1'b0;
    model_err = 0;
    tick(1);
    chk("reset_coincident_byte_ignored", busy_o, 1'b0);
    send(8'h3C); send(8'h89);
    tick(5);
    chk("mid_data_reset_idle", busy_o, 1'b0);
    $display("txn reset_mid_data");

    // Reset during RESP
    tx_ready_i = 1'b0;
    send(SYNC); send(8'h77); send(8'h66);
    push_exp(8'h77, 8'h66, SYNC ^ 8'h77 ^ 8'h66);
    send(SYNC ^ 8'h77 ^ 8'h66);
    tick(2);
    chk("pre_reset_resp", tx_valid_o, 1'b1);
    reset_i = 1'b1;
    tick(1);
    chk_reset_vals("mid_resp_reset");
    rsp_q.delete();
    reset_i    = 1'b0;
    tx_ready_i = 1'b1;
    tick(5);
    chk("mid_resp_no_resp", tx_valid_o, 1'b0);
    chk("mid_resp_idle", busy_o, 1'b0);
    $display("txn reset_mid_resp");

    chk("write_queue_empty", wr_q.size(), 0);
    chk("resp_queue_empty", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, packet header byte.
REQ-002 Parameter ACK_BYTE, default 8'h06, response to a valid packet.
REQ-003 Parameter NAK_BYTE, default 8'h15, response to a checksum failure.
REQ-004 Parameter TIMEOUT, default 20'd520800, max idle cycles between bytes of one packet (5 byte times at 9600 baud, 100 MHz).
REQ-005 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-006 Port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-007 Port reset_i  input  1  synchronous, active-high reset.
REQ-008 Port rx_valid_i  input  1  single-cycle pulse: rx_byte_i holds a received byte.
REQ-009 Port rx_byte_i  input  8  received byte; sampled only when rx_valid_i=1.
REQ-010 Port tx_ready_i  input  1  transmitter accepts tx_byte_o this cycle.
REQ-011 Port wr_en_o  output  1  one-cycle register-write strobe.
REQ-012 Port wr_addr_o  output  8  write address; valid while wr_en_o=1.
REQ-013 Port wr_data_o  output  8  write data; valid while wr_en_o=1.
REQ-014 Port tx_valid_o  output  1  response byte pending.
REQ-015 Port tx_byte_o  output  8  response byte (ACK_BYTE or NAK_BYTE).
REQ-016 Port err_count_o  output  8  saturating count of checksum failures plus timeouts.
REQ-017 Port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-018 Packet format SHALL be: SYNC_BYTE, ADDR, DATA, CSUM, where CSUM = SYNC_BYTE ^ ADDR ^ DATA.
REQ-019 States SHALL be IDLE, ADDR, DATA, CSUM, WRITE, RESP.
REQ-020 IDLE: rx_valid_i with rx_byte_i==SYNC_BYTE -> ADDR; any other byte ignored, IDLE held.
REQ-021 ADDR: rx_valid_i -> capture byte as address, -> DATA.
REQ-022 DATA: rx_valid_i -> capture byte as data, -> CSUM.
REQ-023 CSUM: rx_valid_i with correct checksum -> WRITE; incorrect -> RESP with NAK_BYTE, err_count_o+1.
REQ-024 WRITE: lasts exactly one cycle with wr_en_o=1 and captured addr/data driven; -> RESP with ACK_BYTE.
REQ-025 Latency: wr_en_o SHALL assert the cycle after the CSUM byte pulse; ACK tx_valid_o the cycle after that; NAK tx_valid_o the cycle after the CSUM byte pulse.
REQ-026 RESP: tx_valid_o=1, tx_byte_o stable, held until tx_ready_i=1; that cycle completes the transfer, -> IDLE next cycle.
REQ-027 tx_ready_i=1 outside RESP SHALL have no effect; tx_valid_o SHALL be 0 outside RESP.
REQ-028 rx_valid_i during WRITE or RESP SHALL be dropped without side effects (no error count).
REQ-029 Timeout counter (20 bits) SHALL clear on entering ADDR and on every accepted byte in ADDR/DATA/CSUM, increment every other cycle in those states.
REQ-030 When the counter equals TIMEOUT-1 and rx_valid_i=0: -> IDLE, err_count_o+1, no write, no response.
REQ-031 Simultaneous rx_valid_i and timeout: byte SHALL win; byte accepted, counter cleared, no error.
REQ-032 err_count_o SHALL saturate at 8'hFF; it never wraps.
REQ-033 A SYNC_BYTE value received in ADDR/DATA/CSUM SHALL be treated as ordinary data (no resync).
REQ-034 wr_addr_o/wr_data_o SHALL hold last captured values outside WRITE.

Reset
REQ-035 reset_i=1 at a clock edge SHALL force IDLE, counter 0, wr_en_o=0, tx_valid_o=0, tx_byte_o=8'h00, wr_addr_o=8'h00, wr_data_o=8'h00, err_count_o=8'h00, busy_o=0.
REQ-036 Reset mid-packet or mid-RESP SHALL abandon the packet with no write strobe and no response after reset deasserts.
REQ-037 rx_valid_i coincident with reset_i SHALL be ignored.

Verification
REQ-038 Bytes A5,10,3C,89 with tx_ready_i=1 -> one wr_en_o pulse addr 8'h10 data 8'h3C, then tx_byte_o 8'h06 for one cycle, err_count_o 0.
REQ-039 Bytes A5,10,3C,88 -> no wr_en_o, tx_byte_o 8'h15, err_count_o 1.
REQ-040 Byte A5,10 then no byte for TIMEOUT cycles -> IDLE, busy_o 0, err_count_o 1, no tx_valid_o; following good packet processed normally.
REQ-041 Good packet with tx_ready_i=0 for 50 cycles -> tx_valid_o/tx_byte_o stable 50 cycles, extra rx bytes dropped, IDLE one cycle after tx_ready_i=1.
REQ-042 Bytes 00,FF,A5,A5,A5,A5 -> leading bytes ignored, write addr 8'hA5 data 8'hA5, ACK.
REQ-043 256 consecutive bad-checksum packets -> err_count_o reaches and stays 8'hFF; reset_i during DATA -> all outputs at reset values, no write.
